// File: rtl/seq_divider.sv
// Restoring divider, signed (DIV) or unsigned (DIVU), one quotient bit per clock.
// Latency: WIDTH+1 cycles from accepted start to done; divide-by-zero finishes in 1.
// Backpressure: start is ignored while busy; accepted again in the done cycle.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] rem_w;
    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] dvs_w;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;
    logic             ovf_pend;

    logic             accept;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;

    always_comb begin
        accept  = start && (state == IDLE || state == DONE);
        dvd_abs = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
        dvs_abs = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
        // Partial remainder stays below the divisor, so WIDTH+1 bits hold shift and trial.
        rem_sh  = {rem_w, q_w[WIDTH-1]};
        trial   = rem_sh - {1'b0, dvs_w};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt = (divisor == '0) ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN:     state_nxt = (cnt == LAST) ? FIX : RUN;
            FIX:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN) || (state == FIX);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_w       <= '0;
            q_w         <= '0;
            dvs_w       <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            ovf_pend    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (accept) begin
            rem_w       <= '0;
            q_w         <= dvd_abs;
            dvs_w       <= dvs_abs;
            cnt         <= '0;
            neg_q       <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r       <= signed_op && dividend[WIDTH-1];
            ovf_pend    <= signed_op && (dividend == MIN) && (divisor == '1);
            overflow    <= 1'b0;
            div_by_zero <= (divisor == '0);
            if (divisor == '0) begin
                quotient  <= '1;
                remainder <= dividend;
            end
        end else if (state == RUN) begin
            cnt <= cnt + CW'(1);
            if (!trial[WIDTH]) begin
                rem_w <= trial[WIDTH-1:0];
                q_w   <= {q_w[WIDTH-2:0], 1'b1};
            end else begin
                rem_w <= rem_sh[WIDTH-1:0];
                q_w   <= {q_w[WIDTH-2:0], 1'b0};
            end
        end else if (state == FIX) begin
            // |MIN| / 1 already yields MIN after sign fix-up; only the flag is special.
            quotient  <= neg_q ? -q_w : q_w;
            remainder <= neg_r ? -rem_w : rem_w;
            overflow  <= ovf_pend;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: arithmetic reference model with per-cycle compare,
// directed literal cases, and a randomized start/operand phase.
module tb_seq_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         signed_op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .signed_op  (signed_op),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Reference division straight from the arithmetic definition.
    function automatic void ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic ov);
        logic signed [W-1:0] sa, sb, sq, sr;
        ov = 1'b0;
        if (s && a == 16'h8000 && b == 16'hFFFF) begin
            q  = 16'h8000;
            r  = 16'h0000;
            ov = 1'b1;
        end else if (s) begin
            sa = a;
            sb = b;
            sq = sa / sb;
            sr = sa % sb;
            q  = sq;
            r  = sr;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Model state: outstanding cycles of the in-flight division and the held outputs.
    int           cd = 0;
    logic [W-1:0] pq = '0, pr = '0;
    logic         pov = 1'b0;
    logic [W-1:0] exp_q = '0, exp_r = '0;
    logic         exp_dz = 1'b0, exp_ov = 1'b0, exp_done = 1'b0, exp_busy = 1'b0;
    logic         acc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cd       = 0;
            exp_q    = '0;
            exp_r    = '0;
            exp_dz   = 1'b0;
            exp_ov   = 1'b0;
            exp_done = 1'b0;
            exp_busy = 1'b0;
        end else begin
            acc      = start && (cd == 0);
            exp_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    exp_q    = pq;
                    exp_r    = pr;
                    exp_ov   = pov;
                    exp_done = 1'b1;
                end
            end
            if (acc) begin
                exp_dz = 1'b0;
                exp_ov = 1'b0;
                if (divisor == '0) begin
                    exp_q    = '1;
                    exp_r    = dividend;
                    exp_dz   = 1'b1;
                    exp_done = 1'b1;
                end else begin
                    ref_div(signed_op, dividend, divisor, pq, pr, pov);
                    cd = W + 1;
                end
            end
            exp_busy = (cd > 0);
        end
    end

    always @(negedge clk) begin
        chk("cmp_busy", {15'd0, busy}, {15'd0, exp_busy});
        chk("cmp_done", {15'd0, done}, {15'd0, exp_done});
        chk("cmp_quotient", quotient, exp_q);
        chk("cmp_remainder", remainder, exp_r);
        chk("cmp_div_by_zero", {15'd0, div_by_zero}, {15'd0, exp_dz});
        chk("cmp_overflow", {15'd0, overflow}, {15'd0, exp_ov});
    end

    // Call at a negedge; returns at negedge+1 just after the start edge.
    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        #1;
        start     = 1'b1;
        signed_op = s;
        dividend  = a;
        divisor   = b;
        @(negedge clk);
        #1;
        start     = 1'b0;
        signed_op = 1'($urandom);
        dividend  = W'($urandom);
        divisor   = W'($urandom);
    endtask

    // Counts edges after the start edge until done; returns at a negedge.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
        end
        if (!done) begin
            errors++;
            $display("FAIL done_timeout at %0t: done never rose within 60 cycles", $time);
        end
    endtask

    logic [W-1:0] mq, mr;
    logic         mov;
    int           lat, bc;

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;

        ref_div(1'b0, 16'd100, 16'd7, mq, mr, mov);
        chk("model_divu_q", mq, 16'd14);
        chk("model_divu_r", mr, 16'd2);
        ref_div(1'b1, 16'hFFF9, 16'h0002, mq, mr, mov);
        chk("model_div_q", mq, 16'hFFFD);
        chk("model_div_r", mr, 16'hFFFF);
        ref_div(1'b1, 16'h8000, 16'hFFFF, mq, mr, mov);
        chk("model_ovf_flag", {15'd0, mov}, 16'd1);

        repeat (2) @(negedge clk);
        chk("reset_quotient", quotient, 16'h0000);
        chk("reset_remainder", remainder, 16'h0000);
        chk("reset_busy", {15'd0, busy}, 16'd0);
        chk("reset_done", {15'd0, done}, 16'd0);
        #1 reset = 1'b0;
        @(negedge clk);

        issue(1'b0, 16'h1234, 16'h0000);
        wait_done(lat, bc);
        chk("dbz_latency", W'(lat), 16'd0);
        chk("dbz_quotient", quotient, 16'hFFFF);
        chk("dbz_remainder", remainder, 16'h1234);
        chk("dbz_flag", {15'd0, div_by_zero}, 16'd1);
        chk("dbz_busy", {15'd0, busy}, 16'd0);

        issue(1'b0, 16'd100, 16'd7);
        wait_done(lat, bc);
        chk("divu_latency", W'(lat), 16'd17);
        chk("divu_busy_cycles", W'(bc), 16'd16);
        chk("divu_quotient", quotient, 16'd14);
        chk("divu_remainder", remainder, 16'd2);
        chk("divu_dbz_cleared", {15'd0, div_by_zero}, 16'd0);
        chk("divu_ovf", {15'd0, overflow}, 16'd0);

        issue(1'b1, 16'hFFF9, 16'h0002);
        wait_done(lat, bc);
        chk("div_neg_dvd_q", quotient, 16'hFFFD);
        chk("div_neg_dvd_r", remainder, 16'hFFFF);

        issue(1'b1, 16'h0007, 16'hFFFE);
        wait_done(lat, bc);
        chk("div_neg_dvs_q", quotient, 16'hFFFD);
        chk("div_neg_dvs_r", remainder, 16'h0001);

        issue(1'b1, 16'h8000, 16'hFFFF);
        wait_done(lat, bc);
        chk("ovf_quotient", quotient, 16'h8000);
        chk("ovf_remainder", remainder, 16'h0000);
        chk("ovf_flag", {15'd0, overflow}, 16'd1);

        issue(1'b0, 16'h8000, 16'hFFFF);
        wait_done(lat, bc);
        chk("divu_min_q", quotient, 16'h0000);
        chk("divu_min_r", remainder, 16'h8000);
        chk("divu_min_ovf", {15'd0, overflow}, 16'd0);

        issue(1'b0, 16'd1000, 16'd3);
        repeat (4) @(negedge clk);
        #1;
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd9;
        @(negedge clk);
        #1 start = 1'b0;
        wait_done(lat, bc);
        chk("ignored_start_q", quotient, 16'd333);
        chk("ignored_start_r", remainder, 16'd1);
        issue(1'b0, 16'd9, 16'd9);
        wait_done(lat, bc);
        chk("b2b_latency", W'(lat), 16'd17);
        chk("b2b_quotient", quotient, 16'd1);
        chk("b2b_remainder", remainder, 16'd0);

        issue(1'b0, 16'd1000, 16'd3);
        repeat (7) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrun_reset_q", quotient, 16'h0000);
        chk("midrun_reset_r", remainder, 16'h0000);
        chk("midrun_reset_busy", {15'd0, busy}, 16'd0);
        chk("midrun_reset_done", {15'd0, done}, 16'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        bc = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) bc++;
        end
        chk("no_done_after_reset", W'(bc), 16'd0);
        issue(1'b0, 16'd50, 16'd5);
        wait_done(lat, bc);
        chk("post_reset_latency", W'(lat), 16'd17);
        chk("post_reset_q", quotient, 16'd10);
        chk("post_reset_r", remainder, 16'd0);

        // Random phase: start toggles freely, including while busy.
        for (int i = 0; i < 3000; i++) begin
            int mode;
            @(negedge clk);
            #1;
            mode      = int'($urandom_range(0, 9));
            start     = ($urandom_range(0, 2) == 0);
            signed_op = 1'($urandom);
            dividend  = W'($urandom);
            case (mode)
                0:       divisor = '0;
                1:       begin dividend = 16'h8000; divisor = 16'hFFFF; end
                2:       divisor = W'($urandom_range(1, 15));
                default: divisor = W'($urandom);
            endcase
        end
        #1 start = 1'b0;
        repeat (W + 4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
